// File: rtl/rv32_if_stage.sv
module rv32_if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] code_bus,
  output logic [31:0] pc_id,
  output logic [31:0] pc_plus4_id,
  output logic        id_valid,
  output logic        halted
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DROP,
    ST_HALT
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] fetch_addr;
  logic [31:0] redirect_addr;

  logic        skid_valid;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;

  logic        accepted;
  logic        id_load;
  logic        req_waiting;

  assign redirect_addr = redirect_pc & ~32'd3;
  assign imem_addr     = fetch_addr;

  assign accepted    = (state == ST_RUN) && imem_req && imem_ack && !redirect_valid;
  assign id_load     = !id_stall || !id_valid;
  assign req_waiting = imem_req && !imem_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_RUN: begin
        if (redirect_valid) begin
          if (req_waiting) begin
            state_next = ST_DROP;
          end
        end else if (accepted && (imem_rdata == HALT_INSTR)) begin
          state_next = ST_HALT;
        end
      end
      // The in-flight ack always ends DROP; any redirect seen meanwhile
      // has already been folded into pc, so the next request uses it.
      ST_DROP: begin
        if (imem_ack) begin
          state_next = ST_RUN;
        end
      end
      ST_HALT: begin
        if (redirect_valid) begin
          state_next = ST_RUN;
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    halted   = 1'b0;
    unique case (state)
      ST_RUN:  imem_req = !skid_valid;
      ST_DROP: imem_req = 1'b1;
      ST_HALT: halted   = 1'b1;
      default: imem_req = 1'b0;
    endcase
    if (rst) begin
      imem_req = 1'b0;
    end
  end

  always_comb begin
    pc_next = pc;
    if (redirect_valid) begin
      pc_next = redirect_addr;
    end else if (accepted) begin
      pc_next = pc + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      fetch_addr  <= RESET_PC;
      skid_valid  <= 1'b0;
      skid_instr  <= '0;
      skid_pc     <= '0;
      id_valid    <= 1'b0;
      code_bus    <= NOP_INSTR;
      pc_id       <= '0;
      pc_plus4_id <= 32'd4;
    end else begin
      pc <= pc_next;

      // fetch_addr is frozen while a request is waiting for its ack.
      if (!req_waiting) begin
        fetch_addr <= pc_next;
      end

      if (redirect_valid) begin
        id_valid   <= 1'b0;
        code_bus   <= NOP_INSTR;
        skid_valid <= 1'b0;
      end else if (id_load) begin
        if (skid_valid) begin
          id_valid    <= 1'b1;
          code_bus    <= skid_instr;
          pc_id       <= skid_pc;
          pc_plus4_id <= skid_pc + 32'd4;
          skid_valid  <= 1'b0;
        end else if (accepted) begin
          id_valid    <= 1'b1;
          code_bus    <= imem_rdata;
          pc_id       <= fetch_addr;
          pc_plus4_id <= fetch_addr + 32'd4;
        end else if (state != ST_HALT) begin
          id_valid <= 1'b0;
          code_bus <= NOP_INSTR;
        end
      end else if (accepted) begin
        skid_valid <= 1'b1;
        skid_instr <= imem_rdata;
        skid_pc    <= fetch_addr;
      end
    end
  end

endmodule

// File: tb/tb_rv32_if_stage.sv
module tb_rv32_if_stage;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] code_bus;
  logic [31:0] pc_id;
  logic [31:0] pc_plus4_id;
  logic        id_valid;
  logic        halted;

  logic [31:0] mem [0:255];
  int unsigned wait_cnt;
  int unsigned lat;
  int          n_tests;
  int          n_fail;

  rv32_if_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013),
    .HALT_INSTR(32'hFFFF_FFFF)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .id_stall      (id_stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .code_bus      (code_bus),
    .pc_id         (pc_id),
    .pc_plus4_id   (pc_plus4_id),
    .id_valid      (id_valid),
    .halted        (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_ack   = imem_req && (wait_cnt >= lat);
  assign imem_rdata = mem[imem_addr[9:2]];

  always @(posedge clk) begin
    if (rst || !imem_req || imem_ack) begin
      wait_cnt <= 0;
    end else begin
      wait_cnt <= wait_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    wait_cnt       = 0;
    lat            = 0;
    rst            = 1'b1;
    id_stall       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'hA000_0000 | 32'(i);
    end
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h0010_8113;
    mem[2] = 32'h0020_81B3;

    // Reset state
    tick();
    tick();
    check_eq("rst_req",      {31'd0, imem_req},  32'd0);
    check_eq("rst_valid",    {31'd0, id_valid},  32'd0);
    check_eq("rst_code",     code_bus,           32'h0000_0013);
    check_eq("rst_pc_id",    pc_id,              32'd0);
    check_eq("rst_pc4",      pc_plus4_id,        32'd4);
    check_eq("rst_halted",   {31'd0, halted},    32'd0);
    rst = 1'b0;
    #1;
    check_eq("t1_req",       {31'd0, imem_req},  32'd1);
    check_eq("t1_addr0",     imem_addr,          32'd0);

    // Zero-wait streaming
    tick();
    check_eq("t1_code0",     code_bus,           32'h0050_0093);
    check_eq("t1_pc0",       pc_id,              32'd0);
    check_eq("t1_pc4_0",     pc_plus4_id,        32'd4);
    check_eq("t1_valid",     {31'd0, id_valid},  32'd1);
    check_eq("t1_addr4",     imem_addr,          32'd4);
    tick();
    check_eq("t1_code1",     code_bus,           32'h0010_8113);
    check_eq("t1_pc1",       pc_id,              32'd4);
    check_eq("t1_addr8",     imem_addr,          32'd8);

    // Stall: word@8 lands in the skid, requests pause
    id_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq("t2_hold_code", code_bus,           32'h0010_8113);
      check_eq("t2_hold_pc",   pc_id,              32'd4);
      check_eq("t2_req_low",   {31'd0, imem_req},  32'd0);
    end
    id_stall = 1'b0;
    tick();
    check_eq("t2_skid_code", code_bus,           32'h0020_81B3);
    check_eq("t2_skid_pc",   pc_id,              32'd8);
    check_eq("t2_req",       {31'd0, imem_req},  32'd1);
    check_eq("t2_addr12",    imem_addr,          32'd12);
    tick();
    check_eq("t2_code3",     code_bus,           32'hA000_0003);
    check_eq("t2_pc3",       pc_id,              32'd12);
    check_eq("t2_addr16",    imem_addr,          32'd16);

    // Redirect coincident with an ack
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    tick();
    redirect_valid = 1'b0;
    #1;
    check_eq("t3_valid",     {31'd0, id_valid},  32'd0);
    check_eq("t3_code",      code_bus,           32'h0000_0013);
    check_eq("t3_addr",      imem_addr,          32'h0000_0100);
    tick();
    check_eq("t3_code_tgt",  code_bus,           32'hA000_0040);
    check_eq("t3_pc_tgt",    pc_id,              32'h0000_0100);

    // Redirect during a wait-state fetch
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0010;
    tick();
    redirect_valid = 1'b0;
    lat            = 3;
    #1;
    check_eq("t4_addr_req",  imem_addr,          32'h0000_0010);
    check_eq("t4_ack0",      {31'd0, imem_ack},  32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    tick();
    redirect_valid = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      check_eq("t4_addr_hold", imem_addr,          32'h0000_0010);
      check_eq("t4_req_hold",  {31'd0, imem_req},  32'd1);
      check_eq("t4_no_data",   {31'd0, id_valid},  32'd0);
      if (c < 2) tick();
    end
    check_eq("t4_ack_late",  {31'd0, imem_ack},  32'd1);
    tick();
    check_eq("t4_addr_new",  imem_addr,          32'h0000_0040);
    check_eq("t4_discard_v", {31'd0, id_valid},  32'd0);
    check_eq("t4_discard_c", code_bus,           32'h0000_0013);
    lat = 0;
    tick();
    check_eq("t4_code_new",  code_bus,           32'hA000_0010);
    check_eq("t4_pc_new",    pc_id,              32'h0000_0040);

    // Halt word at 0x8, then redirect out of HALT
    mem[2]         = 32'hFFFF_FFFF;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0008;
    tick();
    redirect_valid = 1'b0;
    #1;
    check_eq("t5_addr8",     imem_addr,          32'h0000_0008);
    for (int c = 0; c < 2; c++) begin
      tick();
      check_eq("t5_code_halt", code_bus,           32'hFFFF_FFFF);
      check_eq("t5_valid",     {31'd0, id_valid},  32'd1);
      check_eq("t5_pc",        pc_id,              32'h0000_0008);
      check_eq("t5_halted",    {31'd0, halted},    32'd1);
      check_eq("t5_req_low",   {31'd0, imem_req},  32'd0);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0020;
    tick();
    redirect_valid = 1'b0;
    #1;
    check_eq("t5_unhalt",    {31'd0, halted},    32'd0);
    check_eq("t5_flush",     {31'd0, id_valid},  32'd0);
    check_eq("t5_req",       {31'd0, imem_req},  32'd1);
    check_eq("t5_addr20",    imem_addr,          32'h0000_0020);
    tick();
    check_eq("t5_code20",    code_bus,           32'hA000_0008);
    check_eq("t5_pc20",      pc_id,              32'h0000_0020);

    // Reset during a wait-state fetch
    lat = 2;
    #1;
    check_eq("t6_ack0",      {31'd0, imem_ack},  32'd0);
    tick();
    check_eq("t6_addr24",    imem_addr,          32'h0000_0024);
    check_eq("t6_wait",      {31'd0, imem_ack},  32'd0);
    rst = 1'b1;
    #1;
    check_eq("t6_req_rst",   {31'd0, imem_req},  32'd0);
    tick();
    check_eq("t6_valid",     {31'd0, id_valid},  32'd0);
    check_eq("t6_code",      code_bus,           32'h0000_0013);
    rst = 1'b0;
    lat = 0;
    #1;
    check_eq("t6_req",       {31'd0, imem_req},  32'd1);
    check_eq("t6_addr0",     imem_addr,          32'd0);
    tick();
    check_eq("t6_code0",     code_bus,           32'h0050_0093);
    check_eq("t6_pc0",       pc_id,              32'd0);

    // Unaligned redirect near the top of the address space: mask and wrap
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    #1;
    check_eq("t7_addr_top",  imem_addr,          32'hFFFF_FFFC);
    tick();
    check_eq("t7_code_top",  code_bus,           32'hA000_00FF);
    check_eq("t7_pc_top",    pc_id,              32'hFFFF_FFFC);
    check_eq("t7_pc4_wrap",  pc_plus4_id,        32'd0);
    check_eq("t7_addr_wrap", imem_addr,          32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32_if_stage.md
Name: rv32_if_stage

Overview:
- Instruction fetch stage of the 5-stage RV32 pipeline; sits directly upstream of the decode control unit.
- Owns the PC and issues word fetches to instruction memory over a req/ack handshake.
- Drives the IF/ID register (code_bus, pc_id, pc_plus4_id, id_valid) consumed by decode.
- Handles decode stalls with a one-entry skid buffer, branch/jump redirects with in-flight fetch discard, and halt on the 32'hFFFF_FFFF halt word.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble word (addi x0,x0,0) driven on code_bus when id_valid=0.
- HALT_INSTR, 32'hFFFF_FFFF, halt word; stops fetching once captured.

Ports:
- clk  in  1  Single clock; all state updates on the rising edge.
- rst  in  1  Synchronous, active-high reset.
- imem_req  out  1  Fetch request.
- imem_addr  out  32  Byte address of the fetch; bits [1:0] always 0.
- imem_ack  in  1  Fetch complete; imem_rdata valid in the same cycle.
- imem_rdata  in  32  Fetched instruction.
- id_stall  in  1  Hazard unit hold: when 1, the IF/ID register holds its contents.
- redirect_valid  in  1  Taken branch, JAL or JALR from EX.
- redirect_pc  in  32  Redirect target; bits [1:0] are forced to 0 internally.
- code_bus  out  32  IF/ID instruction word to decode.
- pc_id  out  32  PC of the instruction on code_bus.
- pc_plus4_id  out  32  pc_id+4 (link value for JAL/JALR); wraps modulo 2^32.
- id_valid  out  1  code_bus holds a real instruction.
- halted  out  1  Fetch stopped on HALT_INSTR.

Behaviour:
- Reset (rst=1 at an edge):
  - pc=RESET_PC; state=RUN.
  - skid empty; id_valid=0; code_bus=NOP_INSTR; pc_id=0; pc_plus4_id=4; halted=0.
  - imem_req=0 while rst=1.
  - A reset mid-fetch abandons the outstanding request; the memory must tolerate this.
- States:
  - RUN: normal fetch.
  - DROP: an outstanding request is to be discarded.
  - HALT: fetch stopped.
- Request and address:
  - imem_req=1 in RUN when the skid is empty; imem_req=1 always in DROP; imem_req=0 in HALT.
  - imem_addr comes from a fetch-address register, loaded from pc when a new request starts.
  - Once imem_req rises, imem_req and imem_addr stay stable until the imem_ack cycle.
- Acceptance and throughput:
  - An ack in RUN without redirect_valid is an accepted fetch, and pc<=pc+4.
  - Zero-wait memory (ack in the request cycle) gives one instruction per cycle.
  - code_bus updates at the edge following the ack.
- IF/ID update, in priority order:
  1. redirect_valid: id_valid<=0, code_bus<=NOP_INSTR, skid cleared, pc<=redirect_pc.
  2. IF/ID can load (id_stall=0 or id_valid=0):
     - Skid full: load from the skid.
     - Else, accepted fetch this cycle: load imem_rdata, with pc_id=fetch address.
     - Else: load a bubble (id_valid=0, code_bus=NOP_INSTR).
  3. Otherwise: IF/ID holds.
- Skid buffer:
  - An accepted fetch while IF/ID is holding is written to the skid.
  - The skid never overflows, because imem_req is low while the skid is full.
- Redirect while a request is outstanding (RUN, imem_req=1, imem_ack=0):
  - pc<=redirect_pc; state->DROP.
  - The old request remains asserted until its ack; that data is discarded; state->RUN.
  - The new request (imem_addr=redirect_pc) starts the cycle after the discarded ack.
- Redirect in other cases:
  - Redirect and ack in the same RUN cycle: data discarded, state stays RUN, and the next request is to redirect_pc.
  - Redirect in DROP: pc updated, state stays DROP.
- Halt:
  - An accepted fetch equal to HALT_INSTR is captured normally (IF/ID or skid) so decode sees it; state->HALT.
  - In HALT: halted=1 and no further requests. IF/ID still drains the skid and then holds the halt word.
  - redirect_valid in HALT (an older branch squashes the halt): flush, pc<=redirect_pc, halted<=0, state->RUN.
- pc_plus4_id always equals pc_id+4, and is registered together with pc_id.

Test Plan:
1. Reset, zero-wait memory returning 0x00500093, 0x00108113, 0x002081B3 → imem_addr 0,4,8 on consecutive cycles; code_bus shows each word one cycle after its ack; pc_id 0,4,8; id_valid=1.
2. id_stall=1 for 3 cycles while code_bus=word@4 → code_bus and pc_id hold; word@8 goes to the skid; imem_req=0 during the stall. After release: word@8 next, then word@12; no loss or duplication.
3. redirect_valid=1, redirect_pc=0x0000_0102, coincident with an ack → next cycle id_valid=0 and code_bus=0x0000_0013; next imem_addr=0x0000_0100.
4. Request to 0x10 acked 3 cycles late, redirect to 0x40 on the first wait cycle → imem_addr stays 0x10 until the ack; the 0x10 data never reaches code_bus; the following request is to 0x40.
5. Memory returns 0xFFFF_FFFF at address 0x8 → code_bus=0xFFFF_FFFF with id_valid=1, halted=1, imem_req stays 0. Then redirect to 0x20 → halted=0 and a request is issued to 0x20.
6. rst asserted during a wait-state fetch → next cycle imem_req=0, id_valid=0, code_bus=NOP_INSTR; the first request after rst falls is to RESET_PC.
